hw_info_regs: RTL

- Parametrised successor of the fixed 16-bit hardware-info register block on the VME slave bus.
- Bus data width is selectable (16 or 32 bits) and the number of read/write scratch registers is configurable.
- Adds a free-running 64-bit uptime counter with a coherent multi-word snapshot-on-read.
- Sits beside the board identification logic, one instance per VME slave.

---
 rtl/hw_info_regs.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/hw_info_regs.sv
// Hardware-info register block for a VME slave: identity words, scratch registers and a 64-bit
// uptime counter with snapshot-on-read. Define HWINFO_BUILD_STAMP_EN to map a 32-bit build stamp.
module hw_info_regs #(
  parameter int unsigned DATA_W      = 16,  // 16 or 32
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned NUM_SCRATCH = 4,   // 1..8
  parameter int unsigned STD_VERSION = 1,
  parameter int unsigned PRESC_DIV   = 1    // 1..65535
) (
  input  logic                          Clk,
  input  logic                          rst_n,
  input  logic [ADDR_W:1]               VMEAddr,
  output logic [DATA_W-1:0]             VMERdData,
  input  logic [DATA_W-1:0]             VMEWrData,
  input  logic                          VMERdMem,
  input  logic                          VMEWrMem,
  output logic                          VMERdDone,
  output logic                          VMEWrDone,
  input  logic [63:0]                   serial_number_i,
  input  logic [23:0]                   fw_version_i,
  input  logic [23:0]                   mm_version_i,
`ifdef HWINFO_BUILD_STAMP_EN
  input  logic [31:0]                   build_stamp_i,
`endif
  output logic [NUM_SCRATCH*DATA_W-1:0] scratch_o,
  output logic [63:0]                   uptime_o
);

  localparam int unsigned WPR     = 64 / DATA_W;
  localparam int unsigned VPR     = 32 / DATA_W;
  localparam int unsigned SN_BASE = 1;
  localparam int unsigned FW_BASE = SN_BASE + WPR;
  localparam int unsigned MM_BASE = FW_BASE + VPR;
  localparam int unsigned UP_BASE = MM_BASE + VPR;
  localparam int unsigned SC_BASE = UP_BASE + WPR;
`ifdef HWINFO_BUILD_STAMP_EN
  localparam int unsigned BS_BASE = SC_BASE + NUM_SCRATCH;
`endif
  localparam logic [15:0] PRESC_LAST = 16'(PRESC_DIV - 1);

  // Word i of a multi-word item, word 0 being the most significant.
  function automatic logic [DATA_W-1:0] word64(logic [63:0] v, int unsigned i);
    logic [63:0] s;
    s = v >> (64 - DATA_W * (i + 1));
    return s[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] word32(logic [31:0] v, int unsigned i);
    logic [31:0] s;
    s = v >> (32 - DATA_W * (i + 1));
    return s[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0]             rd_data_q, rd_data_d, rd_word;
  logic                          rd_done_q;
  logic                          wr_q, wr_done_q;
  logic [ADDR_W-1:0]             wr_addr_q;
  logic [DATA_W-1:0]             wr_data_q;
  logic [NUM_SCRATCH*DATA_W-1:0] scratch_q, scratch_d;
  logic [63:0]                   uptime_q, uptime_d, snap_q, snap_d;
  logic [15:0]                   presc_q, presc_d;
  logic [31:0]                   rd_addr, wr_addr;
  logic                          up_clr;

  assign rd_addr = 32'(VMEAddr);
  assign wr_addr = 32'(wr_addr_q);
  assign up_clr  = wr_q && (wr_addr == UP_BASE);

  // Combinational read decode; unmapped words fall through to zero.
  always_comb begin
    logic [NUM_SCRATCH*DATA_W-1:0] sc_sh;
    rd_word = '0;
    sc_sh   = '0;
    if (rd_addr == 32'd0) rd_word = DATA_W'(STD_VERSION);
    for (int unsigned i = 0; i < WPR; i++) begin
      if (rd_addr == SN_BASE + i) rd_word = word64(serial_number_i, i);
      if (rd_addr == UP_BASE + i) rd_word = (i == 0) ? word64(uptime_q, i) : word64(snap_q, i);
    end
    for (int unsigned i = 0; i < VPR; i++) begin
      if (rd_addr == FW_BASE + i) rd_word = word32({8'h00, fw_version_i}, i);
      if (rd_addr == MM_BASE + i) rd_word = word32({8'h00, mm_version_i}, i);
`ifdef HWINFO_BUILD_STAMP_EN
      if (rd_addr == BS_BASE + i) rd_word = word32(build_stamp_i, i);
`endif
    end
    for (int unsigned k = 0; k < NUM_SCRATCH; k++) begin
      if (rd_addr == SC_BASE + k) begin
        sc_sh   = scratch_q >> (k * DATA_W);
        rd_word = sc_sh[DATA_W-1:0];
      end
    end
  end

  always_comb begin
    rd_data_d = VMERdMem ? rd_word : rd_data_q;
    // Reading the MSW freezes the whole counter so the remaining words stay coherent.
    snap_d    = (VMERdMem && rd_addr == UP_BASE) ? uptime_q : snap_q;
  end

  always_comb begin
    scratch_d = scratch_q;
    if (wr_q) begin
      for (int unsigned k = 0; k < NUM_SCRATCH; k++) begin
        if (wr_addr == SC_BASE + k) scratch_d[k*DATA_W +: DATA_W] = wr_data_q;
      end
    end
  end

  always_comb begin
    presc_d  = presc_q + 16'd1;
    uptime_d = uptime_q;
    if (presc_q == PRESC_LAST) begin
      presc_d  = '0;
      uptime_d = uptime_q + 64'd1;
    end
    if (up_clr) begin
      presc_d  = '0;
      uptime_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_done_q <= 1'b0;
      wr_q      <= 1'b0;
      wr_done_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      scratch_q <= '0;
      uptime_q  <= '0;
      snap_q    <= '0;
      presc_q   <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_done_q <= VMERdMem;
      wr_q      <= VMEWrMem;
      wr_done_q <= wr_q;
      wr_addr_q <= VMEAddr;
      wr_data_q <= VMEWrData;
      scratch_q <= scratch_d;
      uptime_q  <= uptime_d;
      snap_q    <= snap_d;
      presc_q   <= presc_d;
    end
  end

  assign VMERdData = rd_data_q;
  assign VMERdDone = rd_done_q;
  assign VMEWrDone = wr_done_q;
  assign scratch_o = scratch_q;
  assign uptime_o  = uptime_q;

endmodule
